// File: rtl/blvds_transmitter_framer.sv
// rtl/blvds_transmitter_framer.sv - frames FIFO samples into BLVDS link words with headers and checksums
module blvds_transmitter_framer #(
    parameter logic [7:0] GAP_LEN = 8'd16
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iSTART,
    input  logic [7:0]  iPACK_NUM,
    input  logic [15:0] iSAMPLE_NUM,
    input  logic [2:0]  iFORMAT,
    input  logic [3:0]  iCHANNELS,
    input  logic [7:0]  iPACK_SIZE,
    input  logic [15:0] iFIFO_DATA,
    input  logic        iFIFO_EMPTY,
    output logic        oRD_REQ,
    output logic [17:0] oDATA_BLVDS,
    output logic        oBUSY,
    output logic        oDONE,
    output logic        oUNDERRUN_ERROR
);
    localparam logic [17:0] SYNC = 18'h3FE00;

    // State names the word that the next clock edge will put on the link.
    typedef enum logic [3:0] {
        IDLE, FH1, FH2, PH1, PH2, DATA, PE1, PE2, FE1, FE2, GAP
    } state_t;

    state_t      state, nextState, curState;
    logic [7:0]  packNum, packSize, packIdx, gapCnt;
    logic [15:0] sampleNum, sampleCnt;
    logic [3:0]  channels;
    logic [1:0]  frameCnt;
    logic [17:0] packSum, frameSum, word;
    logic [15:0] pCrc, fCrc;
    logic        startOk, lastSample, lastPack, gapDone;

    assign pCrc = ~packSum[15:0];
    assign fCrc = ~frameSum[15:0];

    always_comb begin
        startOk    = iSTART && (iPACK_NUM != 8'd0);
        // A qualified start in IDLE falls straight through into FH1 on the same edge.
        curState   = (state == IDLE && startOk) ? FH1 : state;
        lastSample = (sampleCnt + 16'd1) == sampleNum;
        lastPack   = (packIdx + 8'd1) == packNum;
        gapDone    = (gapCnt + 8'd1) >= GAP_LEN;
        oRD_REQ    = (state == DATA) && !iFIFO_EMPTY;
        nextState  = curState;
        word       = SYNC;
        case (curState)
            IDLE: nextState = IDLE;
            FH1: begin
                word      = {5'b11000, iFORMAT, frameCnt, iPACK_NUM};
                nextState = FH2;
            end
            FH2: begin
                word      = {6'b110010, channels, packSize};
                nextState = PH1;
            end
            PH1: begin
                word      = {5'b11010, packIdx[4:0], sampleNum[15:8]};
                nextState = PH2;
            end
            PH2: begin
                word      = {5'b11011, 5'b00000, sampleNum[7:0]};
                nextState = (sampleNum == 16'd0) ? PE1 : DATA;
            end
            DATA: begin
                if (iFIFO_EMPTY) begin
                    nextState = GAP;
                end else begin
                    word      = {2'b00, iFIFO_DATA};
                    nextState = lastSample ? PE1 : DATA;
                end
            end
            PE1: begin
                word      = {5'b11110, 5'b00000, pCrc[15:8]};
                nextState = PE2;
            end
            PE2: begin
                word      = {5'b11111, 5'b00000, pCrc[7:0]};
                nextState = lastPack ? FE1 : PH1;
            end
            FE1: begin
                word      = {5'b11100, 5'b00000, fCrc[15:8]};
                nextState = FE2;
            end
            FE2: begin
                word      = {5'b11101, 5'b00000, fCrc[7:0]};
                nextState = GAP;
            end
            GAP:     nextState = gapDone ? IDLE : GAP;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oDATA_BLVDS     <= SYNC;
            oBUSY           <= 1'b0;
            oDONE           <= 1'b0;
            oUNDERRUN_ERROR <= 1'b0;
            packNum         <= 8'd0;
            packSize        <= 8'd0;
            sampleNum       <= 16'd0;
            channels        <= 4'd0;
            packIdx         <= 8'd0;
            sampleCnt       <= 16'd0;
            gapCnt          <= 8'd0;
            frameCnt        <= 2'd0;
            packSum         <= 18'd0;
            frameSum        <= 18'd0;
        end else begin
            oDATA_BLVDS     <= word;
            oBUSY           <= (nextState != IDLE);
            oDONE           <= (curState == FE2);
            oUNDERRUN_ERROR <= (curState == DATA) && iFIFO_EMPTY;
            case (curState)
                FH1: begin
                    packNum   <= iPACK_NUM;
                    sampleNum <= iSAMPLE_NUM;
                    channels  <= iCHANNELS;
                    packSize  <= iPACK_SIZE;
                    packIdx   <= 8'd0;
                    frameSum  <= word;
                end
                FH2: frameSum <= frameSum + word;
                PH1: begin
                    packSum  <= word;
                    frameSum <= frameSum + word;
                end
                PH2: begin
                    packSum   <= packSum + word;
                    frameSum  <= frameSum + word;
                    sampleCnt <= 16'd0;
                end
                DATA: begin
                    if (iFIFO_EMPTY) begin
                        gapCnt <= 8'd0;
                    end else begin
                        packSum   <= packSum + word;
                        frameSum  <= frameSum + word;
                        sampleCnt <= sampleCnt + 16'd1;
                    end
                end
                PE1: frameSum <= frameSum + word;
                PE2: begin
                    frameSum <= frameSum + word;
                    packIdx  <= packIdx + 8'd1;
                end
                FE2: begin
                    frameCnt <= frameCnt + 2'd1;
                    gapCnt   <= 8'd0;
                end
                GAP:     gapCnt <= gapCnt + 8'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_blvds_transmitter_framer.sv
// tb/tb_blvds_transmitter_framer.sv - scoreboard bench for blvds_transmitter_framer
module tb_blvds_transmitter_framer;
    localparam logic [17:0] SYNC = 18'h3FE00;

    typedef struct {
        logic [17:0] data;
        logic        done;
        logic        under;
    } exp_t;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iSTART = 1'b0;
    logic [7:0]  iPACK_NUM = 8'd0;
    logic [15:0] iSAMPLE_NUM = 16'd0;
    logic [2:0]  iFORMAT = 3'd0;
    logic [3:0]  iCHANNELS = 4'd0;
    logic [7:0]  iPACK_SIZE = 8'd0;
    logic [15:0] iFIFO_DATA = 16'd0;
    logic        iFIFO_EMPTY = 1'b1;
    logic        oRD_REQ, oBUSY, oDONE, oUNDERRUN_ERROR;
    logic [17:0] oDATA_BLVDS;

    exp_t        expQ[$];
    logic [15:0] fifoQ[$];
    exp_t        monE;
    int          checks = 0;
    int          failures = 0;
    int          rdCount = 0;
    int          expRd = 0;
    logic        rdSeen = 1'b0;
    logic [1:0]  tbFrameCnt = 2'd0;

    blvds_transmitter_framer dut (
        .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iPACK_NUM(iPACK_NUM),
        .iSAMPLE_NUM(iSAMPLE_NUM), .iFORMAT(iFORMAT), .iCHANNELS(iCHANNELS),
        .iPACK_SIZE(iPACK_SIZE), .iFIFO_DATA(iFIFO_DATA), .iFIFO_EMPTY(iFIFO_EMPTY),
        .oRD_REQ(oRD_REQ), .oDATA_BLVDS(oDATA_BLVDS), .oBUSY(oBUSY), .oDONE(oDONE),
        .oUNDERRUN_ERROR(oUNDERRUN_ERROR)
    );

    always #5 iCLK = ~iCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic pushExp(input logic [17:0] d, input logic dn, input logic un);
        exp_t e;
        e.data = d; e.done = dn; e.under = un;
        expQ.push_back(e);
    endtask

    task automatic updFifo();
        iFIFO_EMPTY = (fifoQ.size() == 0);
        iFIFO_DATA  = iFIFO_EMPTY ? 16'h0000 : fifoQ[0];
    endtask

    // Show-ahead FIFO model: a read seen before the edge retires the head after it.
    always @(negedge iCLK) rdSeen = oRD_REQ;
    always @(posedge iCLK) begin
        #1;
        if (rdSeen && fifoQ.size() > 0) fifoQ.delete(0);
        rdSeen = 1'b0;
        updFifo();
    end

    // Monitor: every non-SYNC word, or any flagged word, must match the queue head.
    always @(negedge iCLK) begin
        if (!iRST) begin
            if (oRD_REQ) rdCount++;
            if (oDATA_BLVDS != SYNC || oDONE || oUNDERRUN_ERROR) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word actual=%h done=%b underrun=%b required=none",
                             oDATA_BLVDS, oDONE, oUNDERRUN_ERROR);
                end else begin
                    monE = expQ.pop_front();
                    check("word", 32'(oDATA_BLVDS), 32'(monE.data));
                    check("done", 32'(oDONE), 32'(monE.done));
                    check("underrun", 32'(oUNDERRUN_ERROR), 32'(monE.under));
                end
            end
        end
    end

    task automatic genFrame(input logic [7:0] pn, input logic [15:0] sn, input logic [2:0] fmt,
                            input logic [3:0] ch, input logic [7:0] ps, input int avail);
        logic [17:0] w, fSum, pSum;
        logic [15:0] crc, d;
        int k;
        bit under;
        k = 0; under = 0; pSum = 18'd0;
        w = {5'b11000, fmt, tbFrameCnt, pn}; pushExp(w, 1'b0, 1'b0); fSum = w;
        w = {6'b110010, ch, ps};             pushExp(w, 1'b0, 1'b0); fSum += w;
        for (int p = 0; p < int'(pn) && !under; p++) begin
            w = {5'b11010, 5'(p), sn[15:8]};  pushExp(w, 1'b0, 1'b0); fSum += w; pSum = w;
            w = {5'b11011, 5'b0, sn[7:0]};    pushExp(w, 1'b0, 1'b0); fSum += w; pSum += w;
            for (int s = 0; s < int'(sn) && !under; s++) begin
                if (k >= avail) begin
                    under = 1;
                    pushExp(SYNC, 1'b0, 1'b1);
                end else begin
                    d = 16'h8000 ^ (16'(k) * 16'h0F1D);
                    fifoQ.push_back(d);
                    w = {2'b00, d}; pushExp(w, 1'b0, 1'b0); fSum += w; pSum += w;
                    k++;
                end
            end
            if (!under) begin
                crc = ~pSum[15:0];
                w = {5'b11110, 5'b0, crc[15:8]}; pushExp(w, 1'b0, 1'b0); fSum += w;
                w = {5'b11111, 5'b0, crc[7:0]};  pushExp(w, 1'b0, 1'b0); fSum += w;
            end
        end
        if (!under) begin
            crc = ~fSum[15:0];
            pushExp({5'b11100, 5'b0, crc[15:8]}, 1'b0, 1'b0);
            pushExp({5'b11101, 5'b0, crc[7:0]}, 1'b1, 1'b0);
            tbFrameCnt++;
        end
        expRd = k;
        rdCount = 0;
        updFifo();
    endtask

    task automatic startFrame(input logic [7:0] pn, input logic [15:0] sn, input logic [2:0] fmt,
                              input logic [3:0] ch, input logic [7:0] ps);
        @(negedge iCLK);
        iPACK_NUM = pn; iSAMPLE_NUM = sn; iFORMAT = fmt; iCHANNELS = ch; iPACK_SIZE = ps;
        iSTART = 1'b1;
        @(negedge iCLK);
        iSTART = 1'b0;
        iPACK_NUM = ~pn; iSAMPLE_NUM = ~sn; iFORMAT = ~fmt; iCHANNELS = ~ch; iPACK_SIZE = ~ps;
        check("busy_at_fh1", 32'(oBUSY), 32'd1);
    endtask

    task automatic finishFrame(input string name);
        int n;
        n = 0;
        while ((expQ.size() != 0 || oBUSY) && n < 3000) begin
            @(negedge iCLK);
            n++;
        end
        check({name, "_complete"}, 32'(n < 3000), 32'd1);
        if (n >= 3000) expQ.delete();
        check({name, "_rd_count"}, 32'(rdCount), 32'(expRd));
        check({name, "_idle_sync"}, 32'(oDATA_BLVDS), 32'(SYNC));
    endtask

    task automatic runFrame(input string name, input logic [7:0] pn, input logic [15:0] sn,
                            input logic [2:0] fmt, input logic [3:0] ch, input logic [7:0] ps,
                            input int avail);
        genFrame(pn, sn, fmt, ch, ps, avail);
        startFrame(pn, sn, fmt, ch, ps);
        finishFrame(name);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge iCLK);
        check("rst_data", 32'(oDATA_BLVDS), 32'(SYNC));
        check("rst_busy", 32'(oBUSY), 32'd0);
        check("rst_done", 32'(oDONE), 32'd0);
        check("rst_under", 32'(oUNDERRUN_ERROR), 32'd0);
        check("rst_rd_req", 32'(oRD_REQ), 32'd0);
        iRST = 1'b0;
        repeat (4) @(negedge iCLK);
        check("idle_sync", 32'(oDATA_BLVDS), 32'(SYNC));

        // Start with zero packs must be ignored.
        iPACK_NUM = 8'd0; iSAMPLE_NUM = 16'd5; iSTART = 1'b1;
        repeat (3) @(negedge iCLK);
        iSTART = 1'b0;
        check("zero_pack_busy", 32'(oBUSY), 32'd0);
        check("zero_pack_data", 32'(oDATA_BLVDS), 32'(SYNC));

        // Basic frame with hand-computed words.
        fifoQ.push_back(16'h0001); fifoQ.push_back(16'h0002); updFifo();
        rdCount = 0; expRd = 2;
        pushExp(18'h30001, 1'b0, 1'b0); pushExp(18'h32000, 1'b0, 1'b0);
        pushExp(18'h34000, 1'b0, 1'b0); pushExp(18'h36002, 1'b0, 1'b0);
        pushExp(18'h00001, 1'b0, 1'b0); pushExp(18'h00002, 1'b0, 1'b0);
        pushExp(18'h3C05F, 1'b0, 1'b0); pushExp(18'h3E0FA, 1'b0, 1'b0);
        pushExp(18'h3809E, 1'b0, 1'b0); pushExp(18'h3A0A0, 1'b1, 1'b0);
        tbFrameCnt = 2'd1;
        startFrame(8'd1, 16'd2, 3'd0, 4'd0, 8'd0);
        n = 0;
        while (!oDONE && n < 100) begin
            @(negedge iCLK);
            n++;
        end
        check("basic_done_seen", 32'(n < 100), 32'd1);
        for (int i = 0; i < 16; i++) begin
            @(negedge iCLK);
            check("basic_gap_sync", 32'(oDATA_BLVDS), 32'(SYNC));
        end
        finishFrame("basic");

        runFrame("zero_samples", 8'd3, 16'd0, 3'd2, 4'd6, 8'h21, 0);
        runFrame("underrun", 8'd1, 16'd4, 3'd1, 4'd3, 8'h08, 1);
        runFrame("frame_a", 8'd2, 16'd3, 3'd5, 4'd9, 8'h44, 6);
        runFrame("frame_b", 8'd1, 16'd1, 3'd7, 4'd15, 8'hFF, 1);
        runFrame("frame_c", 8'd1, 16'd2, 3'd3, 4'd1, 8'h10, 2);
        runFrame("pack_wrap", 8'd33, 16'd0, 3'd4, 4'd2, 8'h02, 0);

        // Reset in the middle of the data phase.
        genFrame(8'd1, 16'd8, 3'd3, 4'd4, 8'h10, 8);
        startFrame(8'd1, 16'd8, 3'd3, 4'd4, 8'h10);
        n = 0;
        while (!oRD_REQ && n < 50) begin
            @(negedge iCLK);
            n++;
        end
        check("reached_data", 32'(n < 50), 32'd1);
        @(negedge iCLK);
        #2 iRST = 1'b1;
        #1;
        check("midrst_data", 32'(oDATA_BLVDS), 32'(SYNC));
        check("midrst_rd_req", 32'(oRD_REQ), 32'd0);
        check("midrst_busy", 32'(oBUSY), 32'd0);
        expQ.delete();
        fifoQ.delete();
        updFifo();
        tbFrameCnt = 2'd0;
        repeat (3) @(negedge iCLK);
        iRST = 1'b0;
        repeat (3) @(negedge iCLK);
        check("post_rst_sync", 32'(oDATA_BLVDS), 32'(SYNC));
        runFrame("after_reset", 8'd2, 16'd2, 3'd6, 4'd5, 8'h33, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/blvds_transmitter_framer.md
BLVDS_TRANSMITTER_FRAMER -- requirements
Module: blvds_transmitter_framer

Interface
REQ-001 SHALL have parameter GAP_LEN, default 8'd16, number of SYNC words emitted after each frame or abort.
REQ-002 SHALL have ports:
- iCLK  in  1  clock.
- iRST  in  1  reset, asynchronous, active-high.
- iSTART  in  1  frame request.
- iPACK_NUM  in  8  packs per frame.
- iSAMPLE_NUM  in  16  samples per pack.
- iFORMAT  in  3  header format field.
- iCHANNELS  in  4  channel field.
- iPACK_SIZE  in  8  pack size field.
- iFIFO_DATA  in  16  show-ahead FIFO word.
- iFIFO_EMPTY  in  1  FIFO empty.
- oRD_REQ  out  1  FIFO read acknowledge.
- oDATA_BLVDS  out  18  link word.
- oBUSY  out  1  frame in progress.
- oDONE  out  1  frame complete pulse.
- oUNDERRUN_ERROR  out  1  abort pulse.

Function
REQ-003 SHALL register oDATA_BLVDS and update it once per iCLK; SYNC word = 18'h3FE00.
REQ-004 SHALL use FSM states IDLE, FH1, FH2, PH1, PH2, DATA, PE1, PE2, FE1, FE2, GAP.
REQ-005 IDLE: SHALL emit SYNC; if iSTART=1 and iPACK_NUM!=0, SHALL latch all config inputs and emit FH1 on that same edge; iSTART is ignored in all other states and when iPACK_NUM=0.
REQ-006 Word formats:
- FH1 = {11,000,FORMAT[2:0],FRAME_CNT[1:0],PACK_NUM[7:0]}.
- FH2 = {11,001,0,CHANNELS[3:0],PACK_SIZE[7:0]}.
- PH1 = {11,010,PACK_CNT[4:0],SAMPLE_NUM[15:8]}.
- PH2 = {11,011,00000,SAMPLE_NUM[7:0]}.
- Data = {00,sample}.
- PE1/PE2 = {11,110/111,00000,PCRC[15:8]/[7:0]}.
- FE1/FE2 = {11,100/101,00000,FCRC[15:8]/[7:0]}.
REQ-007 Word order: FH1, FH2, then per pack PH1, PH2, SAMPLE_NUM data words, PE1, PE2; after the last pack FE1, FE2, then GAP.
REQ-008 SAMPLE_NUM=0: SHALL go PH2 -> PE1 with no data words.
REQ-009 oRD_REQ SHALL be combinational: 1 only in DATA with iFIFO_EMPTY=0; on that edge oDATA_BLVDS <= {2'b00,iFIFO_DATA} and the sample counter increments.
REQ-010 Underrun (DATA and iFIFO_EMPTY=1): SHALL emit SYNC, pulse oUNDERRUN_ERROR for 1 cycle, skip FE words, go to GAP; FRAME_CNT is not advanced.
REQ-011 PACK_SUM (18-bit, wraps mod 2^18):
- cleared, then accumulates every word from PH1 through the last data word;
- PCRC = ~PACK_SUM[15:0].
REQ-012 FRAME_SUM (18-bit, wraps mod 2^18):
- accumulates every emitted word from FH1 through the last PE2;
- FE words are excluded;
- FCRC = ~FRAME_SUM[15:0].
REQ-013 PACK_CNT (5-bit) SHALL be 0 for the first pack, +1 per pack, and wrap at 32.
REQ-014 FRAME_CNT (2-bit) SHALL increment mod 4 on each FE2 emission.
REQ-015 oDONE SHALL pulse 1 cycle coincident with FE2 on oDATA_BLVDS.
REQ-016 GAP: SHALL emit SYNC for GAP_LEN cycles, then return to IDLE.
REQ-017 oBUSY SHALL be 1 from FH1 emission until GAP exit, else 0.

Reset
REQ-018 iRST SHALL asynchronously force:
- state IDLE;
- oDATA_BLVDS = 18'h3FE00;
- oBUSY, oDONE, oUNDERRUN_ERROR = 0, and oRD_REQ = 0;
- all counters, sums and latched config = 0.
REQ-019 A reset mid-frame SHALL emit SYNC immediately; the partial frame is abandoned and nothing is resumed after release.

Verification
REQ-020 Reset -> SYNC 0x3FE00 continuous, oBUSY=0, iSTART with iPACK_NUM=0 ignored.
REQ-021 Basic frame:
- stimulus: PACK_NUM=1, SAMPLE_NUM=2, all other config fields 0, FIFO 0x0001, 0x0002;
- required sequence: 0x30001, 0x32000, 0x34000, 0x36002, 0x00001, 0x00002, 0x3C05F, 0x3E0FA, 0x3809E, 0x3A0A0;
- then 16 SYNC words; oDONE high with 0x3A0A0 only.
REQ-022 PACK_NUM=3, SAMPLE_NUM=0:
- three PH1/PH2/PE1/PE2 groups with PACK_CNT 0,1,2, no data words and no oRD_REQ;
- FCRC equals ~(sum of the 14 summed words)[15:0].
REQ-023 Underrun:
- stimulus: FIFO empties after 1 of 4 samples;
- required response: SYNC emitted next cycle, oUNDERRUN_ERROR 1-cycle pulse, no FE words, FRAME_CNT unchanged in the next FH1.
REQ-024 Four consecutive frames -> FH1 FRAME_CNT field 0,1,2,3, then 0 again.
REQ-025 iRST asserted during DATA -> SYNC the same cycle, oRD_REQ=0; after release, a new iSTART produces a full correct frame.
